// File: rtl/noc_common_mem_fifo_pkg.sv
// Shared constants and helpers for the SRAM-backed FIFO controller.
package noc_common_mem_fifo_pkg;

   localparam int unsigned OUT_BUF_DEPTH  = 2;
   localparam int unsigned MEM_RD_LATENCY = 1;

   // Output buffer operation, encoded as {capture, pop}.
   typedef enum logic [1:0] {
      OB_IDLE    = 2'b00,
      OB_POP     = 2'b01,
      OB_CAPTURE = 2'b10,
      OB_BOTH    = 2'b11
   } outbuf_op_e;

   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(depth + OUT_BUF_DEPTH + 1);
   endfunction

endpackage

// File: rtl/noc_common_mem_fifo_outbuf.sv
// Two-entry shift buffer holding SRAM read data; entry 0 is the head.
module noc_common_mem_fifo_outbuf
   import noc_common_mem_fifo_pkg::*;
#(
   parameter int unsigned DATAW = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cap_en_i,
   input  logic [DATAW-1:0] cap_data_i,
   input  logic             pop_en_i,
   output logic [1:0]       cnt_o,
   output logic [DATAW-1:0] head_o
);

   logic [DATAW-1:0] ent_q [OUT_BUF_DEPTH];
   logic [DATAW-1:0] ent_d [OUT_BUF_DEPTH];
   logic [1:0]       cnt_q, cnt_d;
   outbuf_op_e       op;

   always_comb begin
      op    = outbuf_op_e'({cap_en_i, pop_en_i});
      ent_d = ent_q;
      cnt_d = cnt_q;
      unique case (op)
         OB_POP: begin
            ent_d[0] = ent_q[1];
            cnt_d    = cnt_q - 2'd1;
         end
         OB_CAPTURE: begin
            ent_d[cnt_q[0]] = cap_data_i;
            cnt_d           = cnt_q + 2'd1;
         end
         OB_BOTH: begin
            // Shift and append together; count stays the same.
            ent_d[0] = (cnt_q == 2'd2) ? ent_q[1] : cap_data_i;
            ent_d[1] = cap_data_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
      ent_q <= ent_d;
   end

   assign cnt_o  = cnt_q;
   assign head_o = ent_q[0];

endmodule

// File: rtl/noc_common_mem_fifo_ctrl.sv
// FIFO controller using a 1R/1W SRAM as storage, prefetching into a 2-entry output buffer.
module noc_common_mem_fifo_ctrl
   import noc_common_mem_fifo_pkg::*;
#(
   parameter int unsigned DATAW = 64,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned ADDRW = $clog2(DEPTH),
   parameter int unsigned CNTW  = occ_width(DEPTH)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             PushValid,
   output logic             PushReady,
   input  logic [DATAW-1:0] PushData,
   output logic             PopValid,
   input  logic             PopReady,
   output logic [DATAW-1:0] PopData,
   output logic [CNTW-1:0]  Occupancy,
   output logic             RdEn,
   output logic [ADDRW-1:0] RdAddr,
   input  logic [DATAW-1:0] RdData,
   output logic             WrEn,
   output logic [ADDRW-1:0] WrAddr,
   output logic [DATAW-1:0] WrBitEn,
   output logic [DATAW-1:0] WrData
);

   localparam logic [ADDRW:0] MEM_FULL = (ADDRW+1)'(DEPTH);

   logic [ADDRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDRW:0]   mem_cnt_q, mem_cnt_d;
   logic             inflight_q;
   logic [1:0]       out_cnt;
   logic [2:0]       buf_need;
   logic             push_fire, pop_fire, rd_issue;

   assign PushReady = !Rst && (mem_cnt_q < MEM_FULL);
   assign push_fire = PushValid && PushReady;
   assign pop_fire  = PopValid && PopReady;

   // Slots the output buffer will still need after this cycle's pop.
   assign buf_need = 3'(out_cnt) + 3'(inflight_q) - 3'(pop_fire);
   assign rd_issue = !Rst && (mem_cnt_q != '0) && (buf_need < 3'(OUT_BUF_DEPTH));

   assign WrEn    = push_fire;
   assign WrAddr  = wr_ptr_q;
   assign WrData  = PushData;
   assign WrBitEn = '1;
   assign RdEn    = rd_issue;
   assign RdAddr  = rd_ptr_q;

   always_comb begin
      wr_ptr_d  = push_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = rd_issue  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      mem_cnt_d = mem_cnt_q + (ADDRW+1)'(push_fire) - (ADDRW+1)'(rd_issue);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         mem_cnt_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         mem_cnt_q  <= mem_cnt_d;
         inflight_q <= rd_issue;
      end
   end

   noc_common_mem_fifo_outbuf #(
      .DATAW (DATAW)
   ) u_outbuf (
      .clk_i      (Clk),
      .rst_i      (Rst),
      .cap_en_i   (inflight_q),
      .cap_data_i (RdData),
      .pop_en_i   (pop_fire),
      .cnt_o      (out_cnt),
      .head_o     (PopData)
   );

   assign PopValid  = (out_cnt != 2'd0);
   assign Occupancy = CNTW'(mem_cnt_q) + CNTW'(inflight_q) + CNTW'(out_cnt);

   a_no_write_when_full: assert property (@(posedge Clk) disable iff (Rst)
      !(WrEn && (mem_cnt_q == MEM_FULL)));
   a_outbuf_bound: assert property (@(posedge Clk) disable iff (Rst)
      out_cnt <= 2'(OUT_BUF_DEPTH));
   a_occ_bound: assert property (@(posedge Clk) disable iff (Rst)
      Occupancy <= CNTW'(DEPTH + OUT_BUF_DEPTH));

endmodule

// File: doc/noc_common_mem_fifo_ctrl.md
# noc_common_mem_fifo_ctrl

Synchronous FIFO controller that drives a 1-read-port/1-write-port SRAM wrapper (`noc_common_mem_wrap_data_ext` ports) as its storage. It is the requester side of that memory interface. It converts a valid/ready push stream into memory writes, issues prefetch reads, and presents data on a valid/ready pop stream through a 2-entry output buffer. Throughput is one beat per cycle despite the 1-cycle SRAM read latency. It is used in NoC buffering where flop-based FIFOs are too large.

## Interface
- `DATAW`, 64, payload width; equals the memory `DATAW`.
- `DEPTH`, 16, SRAM words (power of two, ≥4); equals the memory `MACRO_DEPTH`.
- `ADDRW`, `$clog2(DEPTH)`, SRAM address width.
- `CNTW`, `$clog2(DEPTH+3)`, occupancy counter width.
- `Clk`  in  1  clock.
- `Rst`  in  1  synchronous, active-high reset.
- `PushValid`  in  1  push request.
- `PushReady`  out  1  FIFO can accept a push.
- `PushData`  in  DATAW  push payload.
- `PopValid`  out  1  head entry available.
- `PopReady`  in  1  consumer accepts the head entry.
- `PopData`  out  DATAW  head payload.
- `Occupancy`  out  CNTW  total entries held (SRAM + in-flight + output buffer).
- `RdEn`  out  1  SRAM read request.
- `RdAddr`  out  ADDRW  SRAM read address.
- `RdData`  in  DATAW  SRAM read data, valid 1 cycle after `RdEn`.
- `WrEn`  out  1  SRAM write request.
- `WrAddr`  out  ADDRW  SRAM write address.
- `WrBitEn`  out  DATAW  write bit enable; always all-ones.
- `WrData`  out  DATAW  SRAM write data.

## Operation
- State registers:
  - `wr_ptr`, `rd_ptr`: ADDRW bits each, wrap naturally modulo DEPTH.
  - `mem_cnt`: 0..DEPTH, committed SRAM entries.
  - `inflight_q`: read issued last cycle.
  - Output buffer `out_cnt`: 0..2.
- Push:
  - `PushReady = !Rst && mem_cnt < DEPTH`.
  - On push fire: `WrEn=1`, `WrAddr=wr_ptr`, `WrData=PushData`, `wr_ptr++`.
  - `WrEn=0` otherwise. `WrBitEn` is constant all-ones.
- Read issue:
  - Condition: `mem_cnt>0 && (out_cnt + inflight_q − pop_fire) < 2`.
  - Action: `RdEn=1`, `RdAddr=rd_ptr`, `rd_ptr++`, `inflight_q<=1`.
  - `RdEn=0` otherwise.
- Capture: when `inflight_q` is set, `RdData` is written into the output buffer tail the same cycle.
- Pop:
  - `PopValid = out_cnt>0`. `PopData` is the head entry.
  - On pop fire the head is shifted out.
  - Simultaneous capture and pop is legal; `out_cnt` is unchanged.
- `mem_cnt` next = `mem_cnt + push_fire − rd_issue`. Simultaneous push and read keep it unchanged.
- Read/write address collision is impossible. A read only targets committed words, and a write only occurs when `mem_cnt<DEPTH`. No bypass path exists.
- `Occupancy = mem_cnt + inflight_q + out_cnt`, maximum DEPTH+2.
- No overflow/underflow is possible by construction. Push with `PushReady=0` and pop with `PopValid=0` are ignored.
- Assertions:
  - `WrEn` never asserted when `mem_cnt==DEPTH`.
  - `out_cnt` never exceeds 2.
  - `Occupancy ≤ DEPTH+2`.

## Timing
- Reset values (registers cleared on the first `Clk` edge with `Rst=1`):
  - `wr_ptr=rd_ptr=mem_cnt=inflight_q=out_cnt=0`.
  - `PopValid=0`, `PushReady=0` while `Rst`, `RdEn=0`, `WrEn=0`, `Occupancy=0`.
- SRAM contents are not cleared.
- Push-to-pop latency on an empty FIFO is 3 cycles:
  - Cycle 0: push and write.
  - Cycle 1: read issued.
  - Cycle 2: `RdData` captured.
  - Cycle 3: `PopValid=1`.
- Steady state is 1 push and 1 pop per cycle with `PopReady` held high.
- `PushReady` depends only on registered state, so there is no combinational path from `PopReady`.
- `PopValid` and `PopData` are registered outputs.
- Reset mid-operation:
  - An in-flight read's data is discarded.
  - All entries are lost.
  - `PushReady` returns to 1 the cycle after `Rst` falls.

## Structure
- Shared package `noc_common_mem_fifo_pkg` holds:
  - `OUT_BUF_DEPTH = 2`.
  - `MEM_RD_LATENCY = 1`.
  - Function `occ_width(depth)` returning `$clog2(depth+OUT_BUF_DEPTH+1)`.
- One natural sub-module: `noc_common_mem_fifo_outbuf`, a 2-entry shift buffer with capture/pop and `out_cnt`.
- Top level holds the pointers, `mem_cnt`, the issue logic and the assertions. Memory instantiation stays outside this block.

## Test plan
- Reset, then single push of `64'hA5A5_0000_0000_0001` → `WrEn` and `WrAddr=0` at cycle 0; `RdEn` and `RdAddr=0` at cycle 1; `PopValid` with the same data at cycle 3; `Occupancy` goes 0→1→1→1→0 after pop.
- Fill with `PopReady=0`, pushing 0..17 → `PushReady` drops after 18 accepted (16 SRAM + 2 buffer), `Occupancy=18`; then pop all and check order 0..17.
- Continuous push/pop with `PopReady=1`, 100 incrementing beats → after 3-cycle fill, one pop per cycle with no bubbles and ordered data.
- Random `PushValid`/`PopReady` (50%) over 2000 beats with a scoreboard → no loss, no reorder, `WrEn` never with `mem_cnt=16`.
- Wrap-around: 40 beats through DEPTH=16 → `WrAddr`/`RdAddr` wrap 15→0 and data is correct.
- `Rst` asserted one cycle after `RdEn` with 5 entries held → next cycle `PopValid=0`, `Occupancy=0`, `RdEn=0`; first post-reset push writes `WrAddr=0`.
